// File: rtl/fetch_pkg.sv
// Shared constants, FSM states and queue entry layout for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W  = 14;
    localparam int INSTR_W = 18;

    localparam logic [ADDR_W-1:0] MEM_BASE_ADDR = 14'h2000;
    localparam logic [ADDR_W-1:0] MEM_TOP_ADDR  = 14'h3FFF;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush dominates push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is reset too so the head presented to the decoder reads zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, buffers fetched instructions for the decoder, handles redirects/faults.
// Optional build macro FETCH_PERF_EN adds saturating push and stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic [ADDR_W-1:0]  o_instr_address,
    input  logic [INSTR_W-1:0] i_instruction,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_pc,
    input  logic               i_instr_ready,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        o_fetch_count,
    output logic [31:0]        o_stall_count
`endif
);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              q_push;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;
    logic              target_legal;
    fetch_entry_t      q_head;

    assign target_legal = (i_redirect_pc >= MEM_BASE_ADDR) && (i_redirect_pc <= MEM_TOP_ADDR);

    // Redirect blocks the handshake so nothing about to be flushed is consumed.
    assign o_instr_valid = !q_empty && !i_redirect_valid;
    assign q_pop         = o_instr_valid && i_instr_ready;
    assign q_push        = (state == FETCH) && !i_redirect_valid && !q_full;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (i_redirect_valid) begin
            pc_next    = i_redirect_pc;
            state_next = target_legal ? FETCH : FAULT;
        end else if (q_push) begin
            pc_next = (pc == MEM_TOP_ADDR) ? MEM_BASE_ADDR : pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= FETCH;
            pc    <= MEM_BASE_ADDR;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .push       (q_push),
        .pop        (q_pop),
        .flush      (i_redirect_valid),
        .push_entry ('{pc: pc, instr: i_instruction}),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head)
    );

    assign o_instr_address = pc;
    assign o_instr         = q_head.instr;
    assign o_instr_pc      = q_head.pc;
    assign o_fault         = (state == FAULT);

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Counters survive redirects; only reset clears them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fetch_count <= '0;
            o_stall_count <= '0;
        end else begin
            if (q_push) begin
                o_fetch_count <= sat_inc(o_fetch_count);
            end
            if ((state == FETCH) && q_full) begin
                o_stall_count <= sat_inc(o_stall_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns a fixed function of the address.
module tb_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [13:0] o_instr_address;
    logic [17:0] i_instruction;
    logic        o_instr_valid;
    logic [17:0] o_instr;
    logic [13:0] o_instr_pc;
    logic        i_instr_ready;
    logic        i_redirect_valid;
    logic [13:0] i_redirect_pc;
    logic        o_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] o_fetch_count;
    logic [31:0] o_stall_count;
`endif

    int total = 0;
    int bad   = 0;

    function automatic logic [17:0] mem_word(input logic [13:0] a);
        return {~a[3:0], a};
    endfunction

    assign i_instruction = mem_word(o_instr_address);

    always #5 i_clk = ~i_clk;

    fetch_unit #(
        .QUEUE_DEPTH (2)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .o_instr_address  (o_instr_address),
        .i_instruction    (i_instruction),
        .o_instr_valid    (o_instr_valid),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .i_instr_ready    (i_instr_ready),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_fault          (o_fault)
`ifdef FETCH_PERF_EN
        ,
        .o_fetch_count    (o_fetch_count),
        .o_stall_count    (o_stall_count)
`endif
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n          = 1'b0;
        i_instr_ready    = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 14'h0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        i_rst_n = 1'b0;
        #1;
        total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_instr_valid); end
        total++; if (o_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", o_fault); end
        total++; if (o_instr_address !== 14'h2000) begin bad++; $display("FAIL reset_addr got=%h exp=2000", o_instr_address); end
        total++; if (o_instr !== 18'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", o_instr); end
        total++; if (o_instr_pc !== 14'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", o_instr_pc); end
    endtask

    task automatic test_stream();
        logic [13:0] exp_pc;
        do_reset();
        i_instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = 14'h2000 + 14'(i);
            total++; if (o_instr_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%b exp=1", i, o_instr_valid); end
            total++; if (o_instr_pc !== exp_pc) begin bad++; $display("FAIL stream_pc%0d got=%h exp=%h", i, o_instr_pc, exp_pc); end
            total++; if (o_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL stream_instr%0d got=%h exp=%h", i, o_instr, mem_word(exp_pc)); end
        end
    endtask

    task automatic test_stall();
        logic [13:0] exp_pc;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        total++; if (o_instr_address !== 14'h2002) begin bad++; $display("FAIL stall_addr got=%h exp=2002", o_instr_address); end
`ifdef FETCH_PERF_EN
        total++; if (o_fetch_count !== 32'd2) begin bad++; $display("FAIL stall_fetch_cnt got=%0d exp=2", o_fetch_count); end
        total++; if (o_stall_count !== 32'd3) begin bad++; $display("FAIL stall_stall_cnt got=%0d exp=3", o_stall_count); end
`endif
        i_instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 14'h2000 + 14'(i);
            total++; if (!(o_instr_valid === 1'b1 && o_instr_pc === exp_pc)) begin
                bad++; $display("FAIL stall_drain%0d got=%b/%h exp=1/%h", i, o_instr_valid, o_instr_pc, exp_pc);
            end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        i_instr_ready    = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 14'h2100;
        #1;
        total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL redir_cycle_valid got=%b exp=0", o_instr_valid); end
        tick();
        i_redirect_valid = 1'b0;
        #1;
        total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL redir_e0_valid got=%b exp=0", o_instr_valid); end
        total++; if (o_instr_address !== 14'h2100) begin bad++; $display("FAIL redir_e0_addr got=%h exp=2100", o_instr_address); end
        tick();
        total++; if (!(o_instr_valid === 1'b1 && o_instr_pc === 14'h2100)) begin
            bad++; $display("FAIL redir_e1_head got=%b/%h exp=1/2100", o_instr_valid, o_instr_pc);
        end
        tick();
        total++; if (!(o_instr_valid === 1'b1 && o_instr_pc === 14'h2101)) begin
            bad++; $display("FAIL redir_e2_head got=%b/%h exp=1/2101", o_instr_valid, o_instr_pc);
        end
    endtask

    task automatic test_wrap();
        logic [13:0] exp_pcs [3];
        exp_pcs[0] = 14'h3FFE;
        exp_pcs[1] = 14'h3FFF;
        exp_pcs[2] = 14'h2000;
        i_instr_ready    = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 14'h3FFE;
        tick();
        i_redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (!(o_instr_valid === 1'b1 && o_instr_pc === exp_pcs[i] && o_instr === mem_word(exp_pcs[i]))) begin
                bad++; $display("FAIL wrap_head%0d got=%b/%h/%h exp=1/%h/%h", i, o_instr_valid, o_instr_pc, o_instr, exp_pcs[i], mem_word(exp_pcs[i]));
            end
        end
    endtask

    task automatic test_fault();
        int seen_valid;
        i_instr_ready    = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 14'h1000;
        tick();
        i_redirect_valid = 1'b0;
        #1;
        total++; if (o_fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b exp=1", o_fault); end
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_instr_valid !== 1'b0) seen_valid++;
        end
        total++; if (seen_valid != 0) begin bad++; $display("FAIL fault_valid_cycles got=%0d exp=0", seen_valid); end
        total++; if (o_instr_address !== 14'h1000) begin bad++; $display("FAIL fault_pc_hold got=%h exp=1000", o_instr_address); end
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 14'h2040;
        tick();
        i_redirect_valid = 1'b0;
        #1;
        total++; if (o_fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", o_fault); end
        tick();
        total++; if (!(o_instr_valid === 1'b1 && o_instr_pc === 14'h2040)) begin
            bad++; $display("FAIL fault_recover_head got=%b/%h exp=1/2040", o_instr_valid, o_instr_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        tick();
        total++; if (!(o_instr_valid === 1'b1 && o_instr_address === 14'h2002)) begin
            bad++; $display("FAIL areset_pre got=%b/%h exp=1/2002", o_instr_valid, o_instr_address);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", o_instr_valid); end
        total++; if (o_instr_address !== 14'h2000) begin bad++; $display("FAIL areset_addr got=%h exp=2000", o_instr_address); end
        total++; if (o_instr_pc !== 14'h0) begin bad++; $display("FAIL areset_pc got=%h exp=0", o_instr_pc); end
        total++; if (o_fault !== 1'b0) begin bad++; $display("FAIL areset_fault got=%b exp=0", o_fault); end
`ifdef FETCH_PERF_EN
        total++; if (o_fetch_count !== 32'd0) begin bad++; $display("FAIL areset_fetch_cnt got=%0d exp=0", o_fetch_count); end
        total++; if (o_stall_count !== 32'd0) begin bad++; $display("FAIL areset_stall_cnt got=%0d exp=0", o_stall_count); end
`endif
        tick();
        i_rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n          = 1'b0;
        i_instr_ready    = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 14'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_fault();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
